// File: rtl/spu_dispatch_pkg.sv
// ----------------------------------------------------------------------------
// spu_dispatch_pkg
// Shared types for the SPU dual-issue dispatch stage.
//   dispatch_state_t : EMPTY (nothing held), PAIR (slot0+slot1 held),
//                      HALF (only slot1 held, slot0 already issued)
//   pipe_t           : execution pipe class of an instruction slot
//   slot_t           : one buffered instruction at the default widths
//   pipe_stalled()   : picks the RAW stall that applies to a pipe class
// ----------------------------------------------------------------------------
package spu_dispatch_pkg;

    localparam int IW_DEF  = 32;
    localparam int PCW_DEF = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PAIR  = 2'd1,
        HALF  = 2'd2
    } dispatch_state_t;

    typedef enum logic {
        PIPE_EVEN = 1'b0,
        PIPE_ODD  = 1'b1
    } pipe_t;

    typedef struct packed {
        logic [IW_DEF-1:0]  instr;
        logic [PCW_DEF-1:0] pc;
        pipe_t              pipe;
    } slot_t;

    function automatic logic pipe_stalled(input logic pipe,
                                          input logic stall_even,
                                          input logic stall_odd);
        return pipe ? stall_odd : stall_even;
    endfunction

endpackage

// File: rtl/spu_issue_select.sv
// ----------------------------------------------------------------------------
// spu_issue_select
// Combinational issue decision for the dispatch stage. Issues in program
// order with at most one instruction per pipe per cycle; slot1 never issues
// ahead of slot0. A taken branch overrides everything: nothing issues and the
// buffer empties.
// Ports:
//   state          in   current dispatch state (dispatch_state_t encoding)
//   pipe0/pipe1    in   pipe class of held slot0/slot1 (0 even, 1 odd)
//   stall_even_raw in   even pipe RAW stall
//   stall_odd_raw  in   odd pipe RAW stall
//   branch_taken   in   odd pipe taken branch (flush)
//   if_valid       in   fetch offering a new pair
//   issue0/issue1  out  slot0/slot1 issues this cycle
//   odd_first      out  the oldest instruction issued this cycle goes odd
//   if_ready       out  buffer drains this cycle and no flush: accept pair
//   next_state     out  state for the next cycle
// ----------------------------------------------------------------------------
module spu_issue_select
    import spu_dispatch_pkg::*;
(
    input  logic [1:0] state,
    input  logic       pipe0,
    input  logic       pipe1,
    input  logic       stall_even_raw,
    input  logic       stall_odd_raw,
    input  logic       branch_taken,
    input  logic       if_valid,
    output logic       issue0,
    output logic       issue1,
    output logic       odd_first,
    output logic       if_ready,
    output logic [1:0] next_state
);

    dispatch_state_t cur_state;
    logic            stall0;
    logic            stall1;
    logic            drained;

    assign cur_state = dispatch_state_t'(state);
    assign stall0    = pipe_stalled(pipe0, stall_even_raw, stall_odd_raw);
    assign stall1    = pipe_stalled(pipe1, stall_even_raw, stall_odd_raw);

    always_comb begin
        issue0     = 1'b0;
        issue1     = 1'b0;
        drained    = 1'b0;
        next_state = EMPTY;
        if (!branch_taken) begin
            case (cur_state)
                PAIR: begin
                    next_state = PAIR;
                    if (!stall0) begin
                        issue0 = 1'b1;
                        // Same-pipe pairs always split: the pipe takes one per cycle.
                        if ((pipe0 != pipe1) && !stall1) begin
                            issue1  = 1'b1;
                            drained = 1'b1;
                        end else begin
                            next_state = HALF;
                        end
                    end
                end
                HALF: begin
                    next_state = HALF;
                    if (!stall1) begin
                        issue1  = 1'b1;
                        drained = 1'b1;
                    end
                end
                default: drained = 1'b1;
            endcase
            // A fully drained buffer refills from fetch in the same cycle.
            if (drained) begin
                next_state = if_valid ? PAIR : EMPTY;
            end
        end
    end

    assign if_ready  = drained;
    assign odd_first = issue0 ? pipe0 : (issue1 & pipe1);

endmodule

// File: rtl/spu_dual_issue_dispatch.sv
// ----------------------------------------------------------------------------
// spu_dual_issue_dispatch
// Issue stage feeding the SPU even and odd pipes. Buffers one fetched
// instruction pair, routes each slot to its pipe class in program order and
// flushes/redirects fetch on a taken odd-pipe branch.
// Optional feature macro: SPU_DISPATCH_PERF_EN enables saturating perf
// counters (dual issue / single issue / held-but-stalled cycles); without it
// the perf ports read 0.
// Ports:
//   clk, reset (async, active-low)
//   if_valid/if_ready, if_instr0/1, if_pipe0/1, if_pc   fetch pair handshake
//   stall_even_raw, stall_odd_raw                       RAW stalls per pipe
//   branch_taken, pc_wb                                 flush + target
//   even_valid/instr/pc, odd_valid/instr/pc, odd_first  registered issue
//   redirect_valid, redirect_pc                         registered redirect
//   perf_dual, perf_single, perf_stall                  perf counters
// ----------------------------------------------------------------------------
module spu_dual_issue_dispatch
    import spu_dispatch_pkg::*;
#(
    parameter int IW     = IW_DEF,
    parameter int PCW    = PCW_DEF,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [IW-1:0]     if_instr0,
    input  logic [IW-1:0]     if_instr1,
    input  logic              if_pipe0,
    input  logic              if_pipe1,
    input  logic [PCW-1:0]    if_pc,
    input  logic              stall_even_raw,
    input  logic              stall_odd_raw,
    input  logic              branch_taken,
    input  logic [PCW-1:0]    pc_wb,
    output logic              even_valid,
    output logic              odd_valid,
    output logic [IW-1:0]     even_instr,
    output logic [IW-1:0]     odd_instr,
    output logic [PCW-1:0]    even_pc,
    output logic [PCW-1:0]    odd_pc,
    output logic              odd_first,
    output logic              redirect_valid,
    output logic [PCW-1:0]    redirect_pc,
    output logic [PERF_W-1:0] perf_dual,
    output logic [PERF_W-1:0] perf_single,
    output logic [PERF_W-1:0] perf_stall
);

    dispatch_state_t     state_reg;
    logic [1:0]          next_state;

    logic [1:0][IW-1:0]  slot_instr_reg;
    logic [1:0][PCW-1:0] slot_pc_reg;
    logic [1:0]          slot_pipe_reg;

    logic [1:0][IW-1:0]  in_instr;
    logic [1:0][PCW-1:0] in_pc;
    logic [1:0]          in_pipe;

    logic                issue0;
    logic                issue1;
    logic                sel_odd_first;
    logic                accept;

    logic                even_take0;
    logic                even_take1;
    logic                odd_take0;
    logic                odd_take1;

    logic                even_valid_reg;
    logic                odd_valid_reg;
    logic [IW-1:0]       even_instr_reg;
    logic [IW-1:0]       odd_instr_reg;
    logic [PCW-1:0]      even_pc_reg;
    logic [PCW-1:0]      odd_pc_reg;
    logic                odd_first_reg;
    logic                redirect_valid_reg;
    logic [PCW-1:0]      redirect_pc_reg;

    // Slot1 pc wraps modulo 2^PCW.
    assign in_instr = {if_instr1, if_instr0};
    assign in_pc    = {if_pc + PCW'(1), if_pc};
    assign in_pipe  = {if_pipe1, if_pipe0};

    spu_issue_select u_select (
        .state          (state_reg),
        .pipe0          (slot_pipe_reg[0]),
        .pipe1          (slot_pipe_reg[1]),
        .stall_even_raw (stall_even_raw),
        .stall_odd_raw  (stall_odd_raw),
        .branch_taken   (branch_taken),
        .if_valid       (if_valid),
        .issue0         (issue0),
        .issue1         (issue1),
        .odd_first      (sel_odd_first),
        .if_ready       (if_ready),
        .next_state     (next_state)
    );

    assign accept = if_valid & if_ready;

    // Slot buffers load only on a full-pair handshake; a flush just moves the
    // state to EMPTY so stale contents are never issued.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    slot_instr_reg[gi] <= '0;
                    slot_pc_reg[gi]    <= '0;
                    slot_pipe_reg[gi]  <= 1'b0;
                end else if (accept) begin
                    slot_instr_reg[gi] <= in_instr[gi];
                    slot_pc_reg[gi]    <= in_pc[gi];
                    slot_pipe_reg[gi]  <= in_pipe[gi];
                end
            end
        end
    endgenerate

    // When both slots issue their pipes differ, so each pipe gets at most one.
    assign even_take0 = issue0 & ~slot_pipe_reg[0];
    assign even_take1 = issue1 & ~slot_pipe_reg[1];
    assign odd_take0  = issue0 &  slot_pipe_reg[0];
    assign odd_take1  = issue1 &  slot_pipe_reg[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg          <= EMPTY;
            even_valid_reg     <= 1'b0;
            odd_valid_reg      <= 1'b0;
            even_instr_reg     <= '0;
            odd_instr_reg      <= '0;
            even_pc_reg        <= '0;
            odd_pc_reg         <= '0;
            odd_first_reg      <= 1'b0;
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            state_reg      <= dispatch_state_t'(next_state);
            even_valid_reg <= even_take0 | even_take1;
            odd_valid_reg  <= odd_take0 | odd_take1;
            if (even_take0) begin
                even_instr_reg <= slot_instr_reg[0];
                even_pc_reg    <= slot_pc_reg[0];
            end else if (even_take1) begin
                even_instr_reg <= slot_instr_reg[1];
                even_pc_reg    <= slot_pc_reg[1];
            end
            if (odd_take0) begin
                odd_instr_reg <= slot_instr_reg[0];
                odd_pc_reg    <= slot_pc_reg[0];
            end else if (odd_take1) begin
                odd_instr_reg <= slot_instr_reg[1];
                odd_pc_reg    <= slot_pc_reg[1];
            end
            odd_first_reg      <= sel_odd_first;
            redirect_valid_reg <= branch_taken;
            if (branch_taken) begin
                redirect_pc_reg <= pc_wb;
            end
        end
    end

    assign even_valid     = even_valid_reg;
    assign odd_valid      = odd_valid_reg;
    assign even_instr     = even_instr_reg;
    assign odd_instr      = odd_instr_reg;
    assign even_pc        = even_pc_reg;
    assign odd_pc         = odd_pc_reg;
    assign odd_first      = odd_first_reg;
    assign redirect_valid = redirect_valid_reg;
    assign redirect_pc    = redirect_pc_reg;

`ifdef SPU_DISPATCH_PERF_EN
    logic [2:0]             perf_evt;
    logic [2:0][PERF_W-1:0] perf_cnt_reg;

    // 0: dual issue, 1: single issue, 2: slots held but nothing issued
    // (includes a flush cycle that discards held slots).
    assign perf_evt[0] = issue0 & issue1;
    assign perf_evt[1] = issue0 ^ issue1;
    assign perf_evt[2] = (state_reg != EMPTY) & ~issue0 & ~issue1;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_perf
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    perf_cnt_reg[gi] <= '0;
                end else if (perf_evt[gi] && (perf_cnt_reg[gi] != '1)) begin
                    perf_cnt_reg[gi] <= perf_cnt_reg[gi] + PERF_W'(1);
                end
            end
        end
    endgenerate

    assign perf_dual   = perf_cnt_reg[0];
    assign perf_single = perf_cnt_reg[1];
    assign perf_stall  = perf_cnt_reg[2];
`else
    assign perf_dual   = '0;
    assign perf_single = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_spu_dual_issue_dispatch.sv
// ----------------------------------------------------------------------------
// tb_spu_dual_issue_dispatch
// Directed scenarios for the dispatch stage plus a randomized run checked
// against an in-order issue model (a queue of held instructions drained
// greedily, one per pipe per cycle, stopping at the first blocked one).
// ----------------------------------------------------------------------------
module tb_spu_dual_issue_dispatch;
    import spu_dispatch_pkg::*;

    localparam int IW     = 32;
    localparam int PCW    = 8;
    localparam int PERF_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_valid;
    logic              if_ready;
    logic [IW-1:0]     if_instr0;
    logic [IW-1:0]     if_instr1;
    logic              if_pipe0;
    logic              if_pipe1;
    logic [PCW-1:0]    if_pc;
    logic              stall_even_raw;
    logic              stall_odd_raw;
    logic              branch_taken;
    logic [PCW-1:0]    pc_wb;
    logic              even_valid;
    logic              odd_valid;
    logic [IW-1:0]     even_instr;
    logic [IW-1:0]     odd_instr;
    logic [PCW-1:0]    even_pc;
    logic [PCW-1:0]    odd_pc;
    logic              odd_first;
    logic              redirect_valid;
    logic [PCW-1:0]    redirect_pc;
    logic [PERF_W-1:0] perf_dual;
    logic [PERF_W-1:0] perf_single;
    logic [PERF_W-1:0] perf_stall;

    int total = 0;
    int bad   = 0;

    spu_dual_issue_dispatch #(.IW(IW), .PCW(PCW), .PERF_W(PERF_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr0      (if_instr0),
        .if_instr1      (if_instr1),
        .if_pipe0       (if_pipe0),
        .if_pipe1       (if_pipe1),
        .if_pc          (if_pc),
        .stall_even_raw (stall_even_raw),
        .stall_odd_raw  (stall_odd_raw),
        .branch_taken   (branch_taken),
        .pc_wb          (pc_wb),
        .even_valid     (even_valid),
        .odd_valid      (odd_valid),
        .even_instr     (even_instr),
        .odd_instr      (odd_instr),
        .even_pc        (even_pc),
        .odd_pc         (odd_pc),
        .odd_first      (odd_first),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .perf_dual      (perf_dual),
        .perf_single    (perf_single),
        .perf_stall     (perf_stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_valid       = 1'b0;
        if_instr0      = '0;
        if_instr1      = '0;
        if_pipe0       = 1'b0;
        if_pipe1       = 1'b0;
        if_pc          = '0;
        stall_even_raw = 1'b0;
        stall_odd_raw  = 1'b0;
        branch_taken   = 1'b0;
        pc_wb          = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
    endtask

    // Instruction words tag slot and pc so misrouting is visible.
    task automatic set_pair(input logic p0, input logic p1, input logic [7:0] pc);
        if_valid  = 1'b1;
        if_pipe0  = p0;
        if_pipe1  = p1;
        if_pc     = pc;
        if_instr0 = {24'hC0DE00, pc};
        if_instr1 = {24'hC0DE01, pc};
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #12;
        total++; if ({even_valid, odd_valid, odd_first, redirect_valid} !== 4'b0)
            begin bad++; $display("FAIL reset_flags got=%b want=0000", {even_valid, odd_valid, odd_first, redirect_valid}); end
        total++; if ({even_instr, odd_instr, even_pc, odd_pc, redirect_pc} !== '0)
            begin bad++; $display("FAIL reset_data got=%h want=0", {even_instr, odd_instr, even_pc, odd_pc, redirect_pc}); end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", if_ready); end
        $display("test_reset done");
    endtask

    task automatic test_dual();
        do_reset();
        set_pair(1'b0, 1'b1, 8'h10);
        #1;
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL dual_ready got=%b want=1", if_ready); end
        tick();
        if_valid = 1'b0;
        tick();
        total++; if ({even_valid, odd_valid, odd_first} !== 3'b110)
            begin bad++; $display("FAIL dual_flags got=%b want=110", {even_valid, odd_valid, odd_first}); end
        total++; if ({even_pc, odd_pc} !== {8'h10, 8'h11})
            begin bad++; $display("FAIL dual_pcs got=%h want=1011", {even_pc, odd_pc}); end
        total++; if ({even_instr, odd_instr} !== {32'hC0DE0010, 32'hC0DE0110})
            begin bad++; $display("FAIL dual_instr got=%h want=c0de0010c0de0110", {even_instr, odd_instr}); end
        tick();
        total++; if ({even_valid, odd_valid} !== 2'b00)
            begin bad++; $display("FAIL dual_one_cycle got=%b want=00", {even_valid, odd_valid}); end
        $display("test_dual done");
    endtask

    task automatic test_odd_odd();
        do_reset();
        set_pair(1'b1, 1'b1, 8'h20);
        tick();
        #1;
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL oo_ready_low got=%b want=0", if_ready); end
        if_valid = 1'b0;
        tick();
        total++; if ({even_valid, odd_valid, odd_first, odd_pc} !== {3'b011, 8'h20})
            begin bad++; $display("FAIL oo_first got=%b/%h want=011/20", {even_valid, odd_valid, odd_first}, odd_pc); end
        tick();
        total++; if ({even_valid, odd_valid, odd_first, odd_pc} !== {3'b011, 8'h21})
            begin bad++; $display("FAIL oo_second got=%b/%h want=011/21", {even_valid, odd_valid, odd_first}, odd_pc); end
        total++; if (odd_instr !== 32'hC0DE0120)
            begin bad++; $display("FAIL oo_second_instr got=%h want=c0de0120", odd_instr); end
        tick();
        total++; if (odd_valid !== 1'b0) begin bad++; $display("FAIL oo_drain got=%b want=0", odd_valid); end
        $display("test_odd_odd done");
    endtask

    task automatic test_stall_odd();
        do_reset();
        set_pair(1'b0, 1'b1, 8'h30);
        stall_odd_raw = 1'b1;
        tick();
        if_valid = 1'b0;
        tick();
        total++; if ({even_valid, odd_valid, even_pc} !== {2'b10, 8'h30})
            begin bad++; $display("FAIL st_even got=%b/%h want=10/30", {even_valid, odd_valid}, even_pc); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if ({even_valid, odd_valid} !== 2'b00)
                begin bad++; $display("FAIL st_hold%0d got=%b want=00", i, {even_valid, odd_valid}); end
        end
        stall_odd_raw = 1'b0;
        tick();
        total++; if ({even_valid, odd_valid, odd_first, odd_pc} !== {3'b011, 8'h31})
            begin bad++; $display("FAIL st_release got=%b/%h want=011/31", {even_valid, odd_valid, odd_first}, odd_pc); end
        $display("test_stall_odd done");
    endtask

    task automatic test_branch();
        do_reset();
        set_pair(1'b0, 1'b1, 8'h50);
        stall_even_raw = 1'b1;
        tick();
        if_valid = 1'b0;
        tick();
        total++; if ({even_valid, odd_valid} !== 2'b00)
            begin bad++; $display("FAIL br_stalled got=%b want=00", {even_valid, odd_valid}); end
        set_pair(1'b0, 1'b1, 8'h60);
        branch_taken = 1'b1;
        pc_wb        = 8'h40;
        #1;
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL br_refuse got=%b want=0", if_ready); end
        tick();
        total++; if ({even_valid, odd_valid, redirect_valid, redirect_pc} !== {3'b001, 8'h40})
            begin bad++; $display("FAIL br_redirect got=%b/%h want=001/40", {even_valid, odd_valid, redirect_valid}, redirect_pc); end
        idle_inputs();
        #1;
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL br_empty_ready got=%b want=1", if_ready); end
        tick();
        total++; if ({even_valid, odd_valid, redirect_valid} !== 3'b000)
            begin bad++; $display("FAIL br_discard got=%b want=000", {even_valid, odd_valid, redirect_valid}); end
        $display("test_branch done");
    endtask

    task automatic test_pc_wrap();
        do_reset();
        set_pair(1'b0, 1'b1, 8'hFF);
        tick();
        if_valid = 1'b0;
        tick();
        total++; if ({even_valid, odd_valid, even_pc, odd_pc} !== {2'b11, 8'hFF, 8'h00})
            begin bad++; $display("FAIL wrap got=%b/%h/%h want=11/ff/00", {even_valid, odd_valid}, even_pc, odd_pc); end
        $display("test_pc_wrap done");
    endtask

    task automatic test_reset_mid_half();
        do_reset();
        set_pair(1'b1, 1'b1, 8'h70);
        tick();
        if_valid = 1'b0;
        tick();
        total++; if (odd_valid !== 1'b1) begin bad++; $display("FAIL rh_setup got=%b want=1", odd_valid); end
        #2 reset = 1'b0;
        #1;
        total++; if ({even_valid, odd_valid, odd_first, redirect_valid, odd_pc, odd_instr} !== '0)
            begin bad++; $display("FAIL rh_async_clear got=%b/%h/%h want=0", {even_valid, odd_valid, odd_first, redirect_valid}, odd_pc, odd_instr); end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL rh_ready got=%b want=1", if_ready); end
        tick();
        total++; if ({even_valid, odd_valid} !== 2'b00)
            begin bad++; $display("FAIL rh_slot_dropped got=%b want=00", {even_valid, odd_valid}); end
        $display("test_reset_mid_half done");
    endtask

    task automatic test_perf();
        int e_d, e_s, e_st;
`ifdef SPU_DISPATCH_PERF_EN
        e_d = 5; e_s = 2; e_st = 3;
`else
        e_d = 0; e_s = 0; e_st = 0;
`endif
        do_reset();
        set_pair(1'b0, 1'b1, 8'h80);
        tick();
        repeat (4) tick();
        if_valid = 1'b0;
        tick();
        set_pair(1'b0, 1'b0, 8'h90);
        tick();
        if_valid = 1'b0;
        repeat (2) tick();
        set_pair(1'b0, 1'b1, 8'hA0);
        stall_even_raw = 1'b1;
        tick();
        if_valid = 1'b0;
        repeat (3) tick();
        total++; if (perf_dual !== PERF_W'(e_d)) begin bad++; $display("FAIL perf_dual got=%0d want=%0d", perf_dual, e_d); end
        total++; if (perf_single !== PERF_W'(e_s)) begin bad++; $display("FAIL perf_single got=%0d want=%0d", perf_single, e_s); end
        total++; if (perf_stall !== PERF_W'(e_st)) begin bad++; $display("FAIL perf_stall got=%0d want=%0d", perf_stall, e_st); end
        stall_even_raw = 1'b0;
        repeat (2) tick();
        $display("test_perf done dual=%0d single=%0d stall=%0d", perf_dual, perf_single, perf_stall);
    endtask

    task automatic test_random(input int n);
        slot_t       mq[$];
        slot_t       s;
        logic        e_ev, e_ov, e_of, e_rv, used_e, used_o, blocked, rdy;
        logic [31:0] e_ei, e_oi;
        logic [7:0]  e_ep, e_op, e_rp;
        int          held, n_iss, c_dual, c_single, c_stall;
        do_reset();
        e_ev = 0; e_ov = 0; e_of = 0; e_rv = 0;
        e_ei = '0; e_oi = '0; e_ep = '0; e_op = '0; e_rp = '0;
        c_dual = 0; c_single = 0; c_stall = 0;
        for (int cyc = 0; cyc < n; cyc++) begin
            if_valid       = ($urandom_range(0, 9) < 6);
            if_instr0      = $urandom();
            if_instr1      = $urandom();
            if_pipe0       = 1'($urandom_range(0, 1));
            if_pipe1       = 1'($urandom_range(0, 1));
            if_pc          = 8'($urandom());
            stall_even_raw = ($urandom_range(0, 3) == 0);
            stall_odd_raw  = ($urandom_range(0, 3) == 0);
            branch_taken   = ($urandom_range(0, 19) == 0);
            pc_wb          = 8'($urandom());
            #3;
            // outputs of the previous cycle's decision
            total++; if ({even_valid, odd_valid, odd_first, redirect_valid} !== {e_ev, e_ov, e_of, e_rv})
                begin bad++; $display("FAIL rnd_flags cyc=%0d got=%b want=%b", cyc, {even_valid, odd_valid, odd_first, redirect_valid}, {e_ev, e_ov, e_of, e_rv}); end
            if (e_ev) begin
                total++; if ({even_instr, even_pc} !== {e_ei, e_ep})
                    begin bad++; $display("FAIL rnd_even cyc=%0d got=%h/%h want=%h/%h", cyc, even_instr, even_pc, e_ei, e_ep); end
            end
            if (e_ov) begin
                total++; if ({odd_instr, odd_pc} !== {e_oi, e_op})
                    begin bad++; $display("FAIL rnd_odd cyc=%0d got=%h/%h want=%h/%h", cyc, odd_instr, odd_pc, e_oi, e_op); end
            end
            if (e_rv) begin
                total++; if (redirect_pc !== e_rp)
                    begin bad++; $display("FAIL rnd_redirect cyc=%0d got=%h want=%h", cyc, redirect_pc, e_rp); end
            end
            // model: drain the held queue in order, one per pipe, stop at first blocked
            held = mq.size(); n_iss = 0; used_e = 0; used_o = 0; blocked = 0;
            e_ev = 0; e_ov = 0; e_of = 0; e_rv = branch_taken;
            if (branch_taken) begin
                e_rp = pc_wb;
                mq.delete();
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (!blocked && mq.size() > 0) begin
                        s = mq[0];
                        if (s.pipe == PIPE_ODD) begin
                            if (stall_odd_raw || used_o) blocked = 1;
                            else begin
                                used_o = 1; e_ov = 1; e_oi = s.instr; e_op = s.pc;
                                if (n_iss == 0) e_of = 1;
                                n_iss++; s = mq.pop_front();
                            end
                        end else begin
                            if (stall_even_raw || used_e) blocked = 1;
                            else begin
                                used_e = 1; e_ev = 1; e_ei = s.instr; e_ep = s.pc;
                                n_iss++; s = mq.pop_front();
                            end
                        end
                    end
                end
            end
            rdy = !branch_taken && (mq.size() == 0);
            total++; if (if_ready !== rdy)
                begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, if_ready, rdy); end
            if (if_valid && rdy) begin
                s.instr = if_instr0; s.pc = if_pc; s.pipe = pipe_t'(if_pipe0);
                mq.push_back(s);
                s.instr = if_instr1; s.pc = 8'(if_pc + 8'd1); s.pipe = pipe_t'(if_pipe1);
                mq.push_back(s);
            end
            if (n_iss == 2) c_dual++;
            else if (n_iss == 1) c_single++;
            else if (held > 0) c_stall++;
            @(posedge clk);
            #1;
        end
`ifndef SPU_DISPATCH_PERF_EN
        c_dual = 0; c_single = 0; c_stall = 0;
`endif
        total++; if ({perf_dual, perf_single, perf_stall} !== {PERF_W'(c_dual), PERF_W'(c_single), PERF_W'(c_stall)})
            begin bad++; $display("FAIL rnd_perf got=%0d/%0d/%0d want=%0d/%0d/%0d", perf_dual, perf_single, perf_stall, c_dual, c_single, c_stall); end
        idle_inputs();
        $display("test_random done cycles=%0d", n);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_dual();
        test_odd_odd();
        test_stall_odd();
        test_branch();
        test_pc_wrap();
        test_reset_mid_half();
        test_perf();
        test_random(600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
